// File: rtl/jump_decoder_ras.sv
// Fetch-bundle jump decoder: per-slot jumpType, first unconditional transfer, RAS-predicted returns.
// One-cycle registered output with valid/ready; restore_valid reloads the RAS checkpoint and kills the output.
module jump_decoder_ras #(
  parameter int SLOTS       = 4,
  parameter int INSTR_WIDTH = 80,
  parameter int IP_WIDTH    = 48,
  parameter int RAS_DEPTH   = 16,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SLOTS*INSTR_WIDTH-1:0] in_instr,
  input  logic [SLOTS*4-1:0]           in_magic,
  input  logic [SLOTS*IP_WIDTH-1:0]    in_ip,
  input  logic [SLOTS*4-1:0]           in_len,
  input  logic [SLOTS-1:0]             in_slot_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SLOTS-1:0]             out_slot_valid,
  output logic [SLOTS*5-1:0]           out_jump_type,
  output logic                         out_taken,
  output logic [SW-1:0]                out_taken_slot,
  output logic [IP_WIDTH-1:0]          out_target,
  output logic                         out_ras_miss,
  output logic [PW-1:0]                out_ras_ptr,
  output logic [PW:0]                  out_ras_count,
  input  logic                         restore_valid,
  input  logic [PW-1:0]                restore_ptr,
  input  logic [PW:0]                  restore_count
);

  logic [SLOTS-1:0]   w_unc, w_ind, w_call, w_ret, w_jmp;
  logic [SLOTS*5-1:0] w_jump_type;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    logic [7:0] w_op;
    logic [2:0] w_f;
    logic [1:0] w_mg;
    logic       w_q, w_cond, w_x, w_b6;
    logic       w_unused;
    assign w_op     = in_instr[g*INSTR_WIDTH +: 8];
    assign w_f      = in_instr[g*INSTR_WIDTH+13 +: 3];
    assign w_mg     = in_magic[g*4 +: 2];
    assign w_q      = w_mg[0] & in_slot_en[g];
    assign w_cond   = w_q & (w_op[7:4] == 4'hA);
    assign w_b6     = w_q & (w_op == 8'd182);
    assign w_x      = (w_mg == 2'b01) ? in_instr[g*INSTR_WIDTH+18] : in_instr[g*INSTR_WIDTH+32];
    assign w_unc[g]  = w_q & (w_op == 8'd181);
    assign w_ind[g]  = w_b6 & (w_f == 3'd0);
    assign w_call[g] = w_b6 & ((w_f == 3'd1) | (w_f == 3'd2));
    assign w_ret[g]  = w_b6 & (w_f == 3'd3);
    assign w_jump_type[g*5 +: 5] = w_cond ? {1'b0, w_x, w_op[3:1]} :
                                   (w_ind[g] | w_ret[g]) ? 5'h11 : 5'h10;
    assign w_unused = ^{in_instr[g*INSTR_WIDTH+48 +: INSTR_WIDTH-48], in_magic[g*4+2 +: 2]};
  end

  assign w_jmp = w_unc | w_ind | w_call | w_ret;

  logic          w_taken;
  logic [SW-1:0] w_taken_slot;
  logic [SLOTS-1:0] w_slot_valid;

  // Slots up to and including the first transfer stay valid; conditionals do not terminate.
  always_comb begin
    w_taken      = 1'b0;
    w_taken_slot = '0;
    w_slot_valid = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_slot_valid[i] = in_slot_en[i] & ~w_taken;
      if (!w_taken && w_jmp[i]) begin
        w_taken      = 1'b1;
        w_taken_slot = SW'(i);
      end
    end
  end

  logic                w_t_unc, w_t_call, w_t_ret, w_t_m1;
  logic [47:8]         w_t_bits;
  logic [IP_WIDTH-1:0] w_t_ip, w_off, w_ret_addr, w_target;
  logic [3:0]          w_t_len;

  assign w_t_unc  = w_taken & w_unc[w_taken_slot];
  assign w_t_call = w_taken & w_call[w_taken_slot];
  assign w_t_ret  = w_taken & w_ret[w_taken_slot];
  assign w_t_m1   = in_magic[w_taken_slot*4 + 1];
  assign w_t_bits = in_instr[w_taken_slot*INSTR_WIDTH + 8 +: 40];
  assign w_t_ip   = in_ip[w_taken_slot*IP_WIDTH +: IP_WIDTH];
  assign w_t_len  = in_len[w_taken_slot*4 +: 4];

  assign w_off = w_t_m1   ? {{(IP_WIDTH-32){w_t_bits[47]}}, w_t_bits[47:17], 1'b0} :
                 w_t_call ? {{(IP_WIDTH-17){w_t_bits[31]}}, w_t_bits[31:16], 1'b0} :
                            {{(IP_WIDTH-25){w_t_bits[31]}}, w_t_bits[31:8],  1'b0};
  assign w_ret_addr = w_t_ip + IP_WIDTH'(w_t_len);

  logic [IP_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]       r_ptr, w_ptr_inc, w_ptr_nxt;
  logic [PW:0]         r_count, w_cnt_nxt;
  logic                w_pop, w_miss, w_accept;

  assign w_ptr_inc = r_ptr + PW'(1);
  assign w_pop     = w_t_ret & (r_count != '0);
  assign w_miss    = w_t_ret & (r_count == '0);

  always_comb begin
    w_target  = '0;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_count;
    if (w_t_unc || w_t_call) w_target = w_t_ip + w_off;
    if (w_pop) begin
      w_target  = r_ras[r_ptr];
      w_ptr_nxt = r_ptr - PW'(1);
      w_cnt_nxt = r_count - (PW+1)'(1);
    end
    if (w_t_call) begin
      w_ptr_nxt = w_ptr_inc;
      // Full stack wraps onto the oldest entry; occupancy saturates.
      if (r_count != (PW+1)'(RAS_DEPTH)) w_cnt_nxt = r_count + (PW+1)'(1);
    end
  end

  logic r_out_valid;
  assign in_ready = ~restore_valid & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (w_accept && w_t_call) r_ras[w_ptr_inc] <= w_ret_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (restore_valid) begin
      r_ptr   <= restore_ptr;
      r_count <= restore_count;
    end else if (w_accept) begin
      r_ptr   <= w_ptr_nxt;
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      out_slot_valid <= '0;
      out_jump_type  <= '0;
      out_taken      <= 1'b0;
      out_taken_slot <= '0;
      out_target     <= '0;
      out_ras_miss   <= 1'b0;
      out_ras_ptr    <= '0;
      out_ras_count  <= '0;
    end else if (restore_valid) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      out_slot_valid <= w_slot_valid;
      out_jump_type  <= w_jump_type;
      out_taken      <= w_taken;
      out_taken_slot <= w_taken_slot;
      out_target     <= w_target;
      out_ras_miss   <= w_miss;
      out_ras_ptr    <= w_ptr_nxt;
      out_ras_count  <= w_cnt_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_jump_decoder_ras.sv
// Randomized + directed bench for jump_decoder_ras: a spec-level model predicts each accepted
// bundle into a queue, and a negedge monitor compares whatever the DUT presents.
module tb_jump_decoder_ras;
  localparam int SLOTS = 4, IW = 80, IPW = 48, D = 16, PW = 4;
  localparam int K_NONE = 0, K_UNC = 1, K_IND = 2, K_CALL = 3, K_RET = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, in_ready, out_valid, out_ready, restore_valid;
  logic [SLOTS*IW-1:0]  in_instr;
  logic [SLOTS*4-1:0]   in_magic, in_len;
  logic [SLOTS*IPW-1:0] in_ip;
  logic [SLOTS-1:0]     in_slot_en, out_slot_valid;
  logic [SLOTS*5-1:0]   out_jump_type;
  logic                 out_taken, out_ras_miss;
  logic [1:0]           out_taken_slot;
  logic [IPW-1:0]       out_target;
  logic [PW-1:0]        out_ras_ptr, restore_ptr;
  logic [PW:0]          out_ras_count, restore_count;

  always #5 clk = ~clk;

  jump_decoder_ras dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_magic(in_magic), .in_ip(in_ip), .in_len(in_len), .in_slot_en(in_slot_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_slot_valid(out_slot_valid),
    .out_jump_type(out_jump_type), .out_taken(out_taken), .out_taken_slot(out_taken_slot),
    .out_target(out_target), .out_ras_miss(out_ras_miss), .out_ras_ptr(out_ras_ptr),
    .out_ras_count(out_ras_count), .restore_valid(restore_valid), .restore_ptr(restore_ptr),
    .restore_count(restore_count)
  );

  typedef struct packed {
    logic [3:0]  sv;
    logic [19:0] jt;
    logic        taken;
    logic [1:0]  tslot;
    logic [47:0] target;
    logic        miss;
    logic [3:0]  ptr;
    logic [4:0]  cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_act;
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0;

  // Reference return-address stack, written straight from the push/pop rules.
  logic [47:0] m_mem [D];
  int          m_ptr, m_cnt;
  bit          m_ov;

  logic [79:0] b_instr [SLOTS];
  logic [3:0]  b_magic [SLOTS];
  logic [47:0] b_ip    [SLOTS];
  logic [3:0]  b_len   [SLOTS];
  logic [3:0]  b_en;

  int cp_p [8];
  int cp_c [8];
  int ncp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_bundle();
    for (int i = 0; i < SLOTS; i++) begin
      b_instr[i] = '0; b_magic[i] = '0; b_ip[i] = '0; b_len[i] = '0;
    end
    b_en = '0;
  endtask

  task automatic set_slot(input int i, input logic [7:0] op, input logic [2:0] f, input logic [3:0] mg,
                          input logic [47:0] ip, input logic [3:0] len, input logic [15:0] imm);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    b_instr[i] = r[79:0];
    b_instr[i][7:0]   = op;
    b_instr[i][15:13] = f;
    b_instr[i][31:16] = imm;
    b_magic[i] = mg; b_ip[i] = ip; b_len[i] = len; b_en[i] = 1'b1;
  endtask

  task automatic rand_slot(input int i);
    int k; logic [7:0] op; logic [2:0] f; logic [1:0] m; logic [63:0] ipr;
    k = $urandom_range(0, 7);
    f = 3'($urandom_range(0, 7));
    case (k)
      0:       op = 8'($urandom_range(0, 255));
      1, 7:    op = {4'hA, 4'($urandom_range(0, 15))};
      2:       op = 8'd181;
      3:       begin op = 8'd182; f = 3'd0; end
      4:       begin op = 8'd182; f = 3'($urandom_range(1, 2)); end
      5:       begin op = 8'd182; f = 3'd3; end
      default: begin op = 8'd182; f = 3'($urandom_range(4, 7)); end
    endcase
    case ($urandom_range(0, 3))
      0, 1:    m = 2'b01;
      2:       m = 2'b11;
      default: m = {1'($urandom_range(0, 1)), 1'b0};
    endcase
    ipr = {$urandom(), $urandom()};
    set_slot(i, op, f, {2'($urandom_range(0, 3)), m}, ipr[47:0], 4'($urandom_range(0, 15)),
             16'($urandom_range(0, 65535)));
    b_en[i] = ($urandom_range(0, 7) != 0);
  endtask

  task automatic pack();
    for (int i = 0; i < SLOTS; i++) begin
      in_instr[i*IW +: IW]   = b_instr[i];
      in_magic[i*4 +: 4]     = b_magic[i];
      in_ip[i*IPW +: IPW]    = b_ip[i];
      in_len[i*4 +: 4]       = b_len[i];
      in_slot_en[i]          = b_en[i];
    end
  endtask

  task automatic model_accept(output exp_t e);
    int ts, tk, k; logic [7:0] op; logic [2:0] f; logic [4:0] jt; logic [79:0] ins;
    logic signed [31:0] s32; logic signed [24:0] s25; logic signed [16:0] s17;
    longint off, sum;
    e = '0; ts = -1; tk = K_NONE;
    for (int i = 0; i < SLOTS; i++) begin
      jt = 5'h10; k = K_NONE;
      if (b_magic[i][0] && b_en[i]) begin
        op = b_instr[i][7:0]; f = b_instr[i][15:13];
        if (op[7:4] == 4'hA)
          jt = {1'b0, (b_magic[i][1:0] == 2'b01) ? b_instr[i][18] : b_instr[i][32], op[3:1]};
        else if (op == 8'd181) k = K_UNC;
        else if (op == 8'd182) begin
          if (f == 3'd0) begin k = K_IND; jt = 5'h11; end
          else if (f == 3'd1 || f == 3'd2) k = K_CALL;
          else if (f == 3'd3) begin k = K_RET; jt = 5'h11; end
        end
      end
      e.jt[i*5 +: 5] = jt;
      if (ts < 0 && k != K_NONE) begin ts = i; tk = k; end
    end
    for (int i = 0; i < SLOTS; i++) e.sv[i] = b_en[i] && (ts < 0 || i <= ts);
    if (ts >= 0) begin
      e.taken = 1'b1; e.tslot = 2'(ts); ins = b_instr[ts];
      s32 = {ins[47:17], 1'b0}; s25 = {ins[31:8], 1'b0}; s17 = {ins[31:16], 1'b0};
      if (b_magic[ts][1]) off = s32;
      else if (tk == K_UNC) off = s25;
      else off = s17;
      sum = longint'({16'h0, b_ip[ts]}) + off;
      case (tk)
        K_UNC: e.target = sum[47:0];
        K_CALL: begin
          e.target = sum[47:0];
          m_ptr = (m_ptr + 1) % D;
          m_mem[m_ptr] = b_ip[ts] + 48'(b_len[ts]);
          if (m_cnt < D) m_cnt++;
        end
        K_RET: begin
          if (m_cnt > 0) begin
            e.target = m_mem[m_ptr];
            m_ptr = (m_ptr + D - 1) % D;
            m_cnt--;
          end else e.miss = 1'b1;
        end
        default: e.target = '0;
      endcase
    end
    e.ptr = 4'(m_ptr); e.cnt = 5'(m_cnt);
  endtask

  // One clock: check in_ready, then apply the model at the edge; returns at posedge+1.
  task automatic cycle();
    logic rdy_exp; exp_t e;
    pack();
    @(negedge clk);
    rdy_exp = !restore_valid && (!m_ov || out_ready);
    chk("in_ready", in_ready, rdy_exp);
    @(posedge clk);
    if (restore_valid) begin
      m_ptr = restore_ptr; m_cnt = restore_count; m_ov = 0; q.delete();
    end else if (in_valid && rdy_exp) begin
      model_accept(e); q.push_back(e); m_ov = 1;
    end else if (out_ready) m_ov = 0;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_act = {out_slot_valid, out_jump_type, out_taken, out_taken_slot, out_target,
                 out_ras_miss, out_ras_ptr, out_ras_count};
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        failures++;
        $display("FAIL out_valid actual=%0b required=%0b", out_valid, q.size() != 0);
      end else if (out_valid) begin
        checks++;
        if (mon_act !== q[0]) begin
          failures++;
          $display("FAIL result actual=%h required=%h", mon_act, q[0]);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int third_ptr, third_cnt;
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_ptr = 0; m_cnt = 0; m_ov = 0;
    clear_bundle(); pack();
    in_valid = 0; out_ready = 1; restore_valid = 0; restore_ptr = '0; restore_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", out_taken, 0);
    chk("rst_miss", out_ras_miss, 0);
    chk("rst_ptr", out_ras_ptr, 0);
    chk("rst_count", out_ras_count, 0);
    chk("rst_fields", {out_slot_valid, out_jump_type, out_taken_slot, out_target}, 0);
    rst = 0;
    #1 mon_en = 1;
    @(posedge clk); #1;

    // call at slot 1 behind a conditional, uncond slots after it get masked
    in_valid = 1; clear_bundle();
    set_slot(0, 8'hA4, 3'd0, 4'b0001, 48'h0ff0, 4'd3, 16'h0004);
    set_slot(1, 8'd182, 3'd1, 4'b0001, 48'h1000, 4'd5, 16'h0010);
    set_slot(2, 8'd181, 3'd0, 4'b0001, 48'h1008, 4'd2, 16'h0100);
    set_slot(3, 8'd181, 3'd0, 4'b0011, 48'h100a, 4'd2, 16'h0100);
    cycle();
    chk("call_tslot", out_taken_slot, 1);
    chk("call_target", out_target, 48'h1020);
    chk("call_slot_valid", out_slot_valid, 4'b0011);
    chk("call_count", out_ras_count, 1);
    clear_bundle(); set_slot(0, 8'd182, 3'd3, 4'b0001, 48'h5000, 4'd2, 16'h0);
    cycle();
    chk("ret_target", out_target, 48'h1005);
    chk("ret_count", out_ras_count, 0);
    cycle();
    chk("empty_miss", out_ras_miss, 1);
    chk("empty_target", out_target, 0);
    chk("empty_ptr_cnt", {out_ras_ptr, out_ras_count}, 0);

    // 17 calls overwrite the oldest entry, 16 rets unwind, 17th misses
    for (int k = 0; k <= 16; k++) begin
      clear_bundle();
      set_slot(0, 8'd182, 3'($urandom_range(1, 2)), 4'b0001, 48'(k * 256), 4'd4,
               16'($urandom_range(0, 65535)));
      cycle();
    end
    chk("full_count", out_ras_count, 16);
    for (int j = 0; j < 16; j++) begin
      clear_bundle(); set_slot(0, 8'd182, 3'd3, 4'b0011, 48'h9000, 4'd1, 16'h0);
      cycle();
      chk("unwind_target", out_target, 48'((16 - j) * 256 + 4));
    end
    cycle();
    chk("unwind_miss", out_ras_miss, 1);

    // stall: held bundle must not push again
    in_valid = 0; cycle();
    out_ready = 0; in_valid = 1;
    clear_bundle(); set_slot(0, 8'd182, 3'd1, 4'b0001, 48'h3000, 4'd2, 16'h0040);
    cycle();
    clear_bundle(); set_slot(0, 8'd182, 3'd2, 4'b0011, 48'h3100, 4'd2, 16'h0);
    repeat (3) begin
      cycle();
      chk("stall_count", out_ras_count, 1);
    end
    out_ready = 1; cycle();
    chk("stall_release_count", out_ras_count, 2);
    in_valid = 0; cycle();

    // checkpoint / restore
    in_valid = 1; third_ptr = 0; third_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      clear_bundle(); set_slot(0, 8'd182, 3'd1, 4'b0001, 48'(32'h2000 + 16 * j), 4'd3, 16'h0);
      cycle();
      if (j == 2) begin third_ptr = m_ptr; third_cnt = m_cnt; end
    end
    restore_valid = 1; restore_ptr = 4'(third_ptr); restore_count = 5'(third_cnt);
    clear_bundle(); set_slot(0, 8'd182, 3'd1, 4'b0001, 48'h7000, 4'd3, 16'h0);
    cycle();
    chk("restore_kill", out_valid, 0);
    restore_valid = 0;
    clear_bundle(); set_slot(0, 8'd182, 3'd3, 4'b0001, 48'h7100, 4'd3, 16'h0);
    cycle();
    chk("restore_ret", out_target, 48'h2023);

    // asynchronous reset while holding a result with count 5
    in_valid = 0; restore_valid = 1; restore_ptr = '0; restore_count = '0; cycle();
    restore_valid = 0; in_valid = 1;
    for (int j = 0; j < 5; j++) begin
      clear_bundle(); set_slot(0, 8'd182, 3'd1, 4'b0001, 48'(32'h4000 + 16 * j), 4'd1, 16'h0);
      cycle();
    end
    out_ready = 0; in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_count", out_ras_count, 5);
    mon_en = 0;
    #1 rst = 1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", out_ras_count, 0);
    chk("async_rst_ptr", out_ras_ptr, 0);
    @(posedge clk); @(negedge clk);
    rst = 0; m_ptr = 0; m_cnt = 0; m_ov = 0; q.delete();
    #1 mon_en = 1;
    @(posedge clk); #1;
    out_ready = 1; in_valid = 1;
    clear_bundle(); set_slot(0, 8'd182, 3'd3, 4'b0001, 48'h6000, 4'd1, 16'h0);
    cycle();
    chk("post_rst_miss", out_ras_miss, 1);

    // randomized traffic with occasional restores to earlier model checkpoints
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      restore_valid = (ncp > 0) && ($urandom_range(0, 31) == 0);
      if (restore_valid) begin
        int j;
        j = $urandom_range(0, (ncp < 8 ? ncp : 8) - 1);
        restore_ptr = 4'(cp_p[j]); restore_count = 5'(cp_c[j]);
      end
      for (int i = 0; i < SLOTS; i++) rand_slot(i);
      cycle();
      cp_p[ncp % 8] = m_ptr; cp_c[ncp % 8] = m_cnt; ncp++;
    end
    restore_valid = 0; in_valid = 0; out_ready = 1;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jump_decoder_ras.md
Name: jump_decoder_ras

Overview:
Bundle-wide jump decoder for the frontend. Each accepted fetch bundle carries up to SLOTS instructions. The block classifies every slot's control-flow type and finds the first unconditional transfer. It resolves that transfer's target, using an internal circular return-address stack (RAS) to predict returns. The result is a one-entry registered output with valid/ready handshake, and the RAS checkpoint can be restored on a backend flush.

Parameters:
SLOTS, 4, instruction slots per bundle
INSTR_WIDTH, 80, bits per instruction slot
IP_WIDTH, 48, instruction address width
RAS_DEPTH, 16, return-address-stack entries (power of 2, >=2); PW=$clog2(RAS_DEPTH)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  bundle present
in_ready  output  1  bundle accepted when in_valid&in_ready
in_instr  input  SLOTS*INSTR_WIDTH  slot i at [i*INSTR_WIDTH +: INSTR_WIDTH]
in_magic  input  SLOTS*4  per-slot length/format magic
in_ip  input  SLOTS*IP_WIDTH  per-slot instruction address
in_len  input  SLOTS*4  per-slot byte length
in_slot_en  input  SLOTS  slot holds a real instruction
out_valid  output  1  registered result valid
out_ready  input  1  consumer takes result
out_slot_valid  output  SLOTS  slot enabled and not after the first taken slot
out_jump_type  output  SLOTS*5  per-slot jumpType
out_taken  output  1  bundle has an unconditional transfer
out_taken_slot  output  $clog2(SLOTS)  index of that slot
out_target  output  IP_WIDTH  predicted target; 0 when indirect or out_taken=0
out_ras_miss  output  1  return executed on empty RAS
out_ras_ptr  output  PW  RAS top pointer after this bundle (checkpoint)
out_ras_count  output  PW+1  RAS occupancy after this bundle
restore_valid  input  1  flush: reload RAS checkpoint
restore_ptr  input  PW  checkpoint pointer
restore_count  input  PW+1  checkpoint occupancy

Behaviour:
- Per-slot decode (op=instr[7:0], qualified by magic[0]=1 and in_slot_en):
  - cond: op[7:4]=4'hA; jumpType={0,x,op[3:1]}, x=instr[18] if magic[1:0]=01, else instr[32].
  - uncond: op=181; type 5'h10.
  - indir: op=182 with f=instr[15:13]=0; type 5'h11.
  - call: op=182 with f=1 or 2; type 5'h10.
  - ret: op=182 with f=3; type 5'h11.
  - Any other slot: type 5'h10, non-jump.
- Taken slot = lowest-index slot that is uncond, indir, call or ret. out_slot_valid clears all higher slots. Cond slots never terminate the bundle.
- Offset is sign-extended and computed mod 2^IP_WIDTH:
  - magic[1:0]=01: uncond uses {instr[31:8],0}; call uses {instr[31:16],0}.
  - magic[1:0]=11: {instr[47:17],0}.
- Targets by taken type:
  - uncond/call: ip+offset.
  - ret: RAS top, or 0 with out_ras_miss=1 if count=0.
  - indir: 0.
- RAS acts only for the taken slot, so there is at most one push or pop per bundle, applied at acceptance.
  - Push (call): write ip+len at ptr+1 (mod RAS_DEPTH), ptr++, count=min(count+1,RAS_DEPTH). When full, the oldest entry is silently overwritten.
  - Pop (ret) when count>0: read entry[ptr], ptr--, count--. When count=0: ptr and count are unchanged.
- Handshake: in_ready = ~out_valid | out_ready. An accepted bundle appears on out_* the next cycle (latency 1). The output register holds while out_valid&~out_ready.
- restore_valid beats any accept in the same cycle:
  - ptr<=restore_ptr, count<=restore_count.
  - out_valid<=0; in_ready is forced 0 that cycle.
  - Stack entries are not modified.
- Reset: out_valid, out_taken, out_ras_miss, out_ras_ptr, out_ras_count, internal ptr and count go to 0. All other out_* fields go to 0. Stack entries are not reset.
- Reset mid-operation discards the held output. The first bundle after reset sees an empty RAS.

Test Plan:
- call at slot1 (ip=0x1000, len=5, magic=01, instr[31:16]=0x0010), slot0 cond → out_taken_slot=1, target=0x1020, slot_valid=0011, ras_count=1; next bundle with ret at slot0 → target=0x1005, ras_count=0.
- ret on empty RAS → out_ras_miss=1, target=0, ptr/count stay 0.
- 17 calls with RAS_DEPTH=16, ip_k=0x100*k, len=4; then 16 rets → targets return 0x1004 down to 0x104; 17th ret → miss.
- out_ready=0 for 3 cycles with in_valid held → in_ready=0, output stable; RAS pushed once only.
- 3 pushes, checkpoint ptr/count taken, 2 more pushes, restore_valid with the checkpoint and in_valid together → bundle not accepted, out_valid=0; next ret → third pushed address.
- rst asserted while out_valid=1 with count=5 → out_valid=0 and count=0 immediately (asynchronous), before the next clk edge.
